// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO, programmable bit period and
// per-frame parity / stop-bit configuration latched when each word is popped.
module uart_tx_fifo #(
  parameter int unsigned DATAWIDTH     = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned PTRWIDTH      = 2,
  parameter int unsigned PRESCALEWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATAWIDTH-1:0]     P_DATA,
  input  logic                     DATA_VALID,
  output logic                     READY,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  input  logic                     STOP2,
  input  logic [PRESCALEWIDTH-1:0] PRESCALE,
  output logic                     TX_OUT,
  output logic                     Busy,
  output logic [PTRWIDTH:0]        FIFO_CNT
);

  localparam int unsigned CNTW = PTRWIDTH + 1;
  localparam int unsigned BITW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  logic [DATAWIDTH-1:0]     mem [FIFO_DEPTH];
  logic [PTRWIDTH-1:0]      wr_ptr, rd_ptr;
  logic                     push, pop;
  logic [CNTW-1:0]          cnt_d;

  state_t                   state_q, state_d;
  logic [PRESCALEWIDTH-1:0] dwell_q, dwell_d;
  logic [PRESCALEWIDTH-1:0] presc_q, presc_d, presc_new;
  logic [BITW-1:0]          bit_q, bit_d;
  logic [DATAWIDTH-1:0]     shift_q, shift_d;
  logic                     par_en_q, par_en_d;
  logic                     par_bit_q, par_bit_d;
  logic                     stop2_q, stop2_d;
  logic                     frame_end, dwell_done, tx_d;

  assign push       = DATA_VALID && READY;
  assign dwell_done = (dwell_q == '0);
  assign presc_new  = (PRESCALE == '0) ? PRESCALEWIDTH'(1) : PRESCALE;

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= P_DATA;
  end

  always_comb begin
    cnt_d = FIFO_CNT;
    case ({push, pop})
      2'b10:   cnt_d = FIFO_CNT + CNTW'(1);
      2'b01:   cnt_d = FIFO_CNT - CNTW'(1);
      default: cnt_d = FIFO_CNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      FIFO_CNT <= '0;
      READY    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRWIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRWIDTH'(1);
      FIFO_CNT <= cnt_d;
      READY    <= (cnt_d != CNTW'(FIFO_DEPTH));
    end
  end

  // Next-state logic; frame_end marks a point where a new frame may begin
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    presc_d   = presc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    pop       = 1'b0;
    frame_end = 1'b0;

    if (state_q != S_IDLE) begin
      dwell_d = dwell_done ? (presc_q - PRESCALEWIDTH'(1)) : (dwell_q - PRESCALEWIDTH'(1));
    end

    case (state_q)
      S_IDLE:   frame_end = 1'b1;
      S_START: begin
        if (dwell_done) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (dwell_done) begin
          if (bit_q == BITW'(DATAWIDTH - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            bit_d   = bit_q + BITW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: if (dwell_done) state_d = S_STOP1;
      S_STOP1: begin
        if (dwell_done) begin
          if (stop2_q) state_d = S_STOP2;
          else         frame_end = 1'b1;
        end
      end
      S_STOP2:  if (dwell_done) frame_end = 1'b1;
      default:  state_d = S_IDLE;
    endcase

    if (frame_end) begin
      if (FIFO_CNT != '0) begin
        pop       = 1'b1;
        state_d   = S_START;
        shift_d   = mem[rd_ptr];
        par_en_d  = PAR_EN;
        par_bit_d = (^mem[rd_ptr]) ^ PAR_TYP;
        stop2_d   = STOP2;
        presc_d   = presc_new;
        dwell_d   = presc_new - PRESCALEWIDTH'(1);
      end else begin
        state_d   = S_IDLE;
      end
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dwell_q   <= '0;
      presc_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      TX_OUT    <= tx_d;
      Busy      <= (state_d != S_IDLE);
    end
  end

endmodule
